// File: rtl/scl_generate.sv
`default_nettype none
// ============================================================================
// Module   : scl_generate
// Purpose  : I2C master SCL timing stage. Produces SCL, the per-phase cycle
//            counter, the bit index within a byte and the bit-boundary
//            strobes consumed by the SDA/state FSM (sda_generate). Honours
//            slave clock stretching during the SCL high phase.
// Revision : 1.0 - initial release
// ============================================================================
module scl_generate #(
  parameter int ADDR_LEN        = 7,
  parameter int DATA_LEN        = 8,
  parameter int SETUP_SDA_START = 2,
  parameter int HOLD_START      = 4,
  parameter int T_HIGH          = 4,
  parameter int T_LOW           = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] state_master,
  input  logic       free,
  input  logic       rst_count,
  input  logic       scl_in,
  output logic       scl,
  output logic [6:0] count_ctrl,
  output logic [3:0] count,
  output logic       wait_for_sync,
  output logic       add_sent,
  output logic       data_sent,
  output logic       data_received
);

  // Master FSM encodings that this block reacts to
  localparam logic [3:0] SM_READY        = 4'd1;
  localparam logic [3:0] SM_SEND_ADDRESS = 4'd2;
  localparam logic [3:0] SM_OUTPUT_DATA  = 4'd4;
  localparam logic [3:0] SM_STORE_DATA   = 4'd7;
  localparam logic [3:0] SM_STOP         = 4'd11;

  // Terminal counts of each phase
  localparam logic [6:0] START_LAST = 7'(SETUP_SDA_START + HOLD_START - 1);
  localparam logic [6:0] LOW_LAST   = 7'(T_LOW - 1);
  localparam logic [6:0] HIGH_LAST  = 7'(T_HIGH - 1);
  localparam logic [6:0] CTRL_MAX   = 7'h7F;
  localparam logic [3:0] ADDR_LAST  = 4'(ADDR_LEN);
  localparam logic [3:0] DATA_LAST  = 4'(DATA_LEN - 1);

  typedef enum logic [2:0] {
    G_IDLE  = 3'd0,
    G_START = 3'd1,
    G_LOW   = 3'd2,
    G_HIGH  = 3'd3,
    G_STOP  = 3'd4
  } gen_state_t;

  gen_state_t state_q, state_d;
  logic       scl_q, scl_d;
  logic [6:0] count_ctrl_q, count_ctrl_d;
  logic [3:0] count_q, count_d;
  logic       wait_for_sync_q, wait_for_sync_d;
  logic       add_sent_q, add_sent_d;
  logic       data_sent_q, data_sent_d;
  logic       data_received_q, data_received_d;
  logic       abort;
  logic       bit_end;
  logic       high_last_next;

  // Next-state, phase counter, bit index and strobe computation
  always_comb begin
    state_d      = state_q;
    scl_d        = scl_q;
    count_ctrl_d = count_ctrl_q;
    count_d      = count_q;
    abort        = 1'b0;
    bit_end      = 1'b0;

    case (state_q)
      G_IDLE: begin
        scl_d        = 1'b1;
        count_ctrl_d = 7'd0;
        if (state_master == SM_READY) begin
          state_d = G_START;
        end
      end
      G_START: begin
        if (free) begin
          abort = 1'b1;
        end else if (count_ctrl_q == START_LAST) begin
          state_d      = G_LOW;
          scl_d        = 1'b0;
          count_ctrl_d = 7'd0;
        end else begin
          count_ctrl_d = count_ctrl_q + 7'd1;
        end
      end
      G_LOW: begin
        if (free) begin
          abort = 1'b1;
        end else if (count_ctrl_q == LOW_LAST) begin
          count_ctrl_d = 7'd0;
          if (state_master == SM_STOP) begin
            // SCL stays low one more cycle so SDA can settle low before STOP
            state_d = G_STOP;
            scl_d   = 1'b0;
          end else begin
            state_d = G_HIGH;
            scl_d   = 1'b1;
          end
        end else begin
          count_ctrl_d = count_ctrl_q + 7'd1;
        end
      end
      G_HIGH: begin
        if (free) begin
          abort = 1'b1;
        end else if (count_ctrl_q == HIGH_LAST) begin
          state_d      = G_LOW;
          scl_d        = 1'b0;
          count_ctrl_d = 7'd0;
          bit_end      = 1'b1;
        end else if (!scl_in) begin
          // Slave is stretching: the high phase only starts once SCL is seen high
          count_ctrl_d = 7'd0;
        end else begin
          count_ctrl_d = count_ctrl_q + 7'd1;
        end
      end
      G_STOP: begin
        scl_d = 1'b1;
        if (free) begin
          state_d      = G_IDLE;
          count_ctrl_d = 7'd0;
        end else if (count_ctrl_q != CTRL_MAX) begin
          count_ctrl_d = count_ctrl_q + 7'd1;
        end
      end
      default: begin
        state_d      = G_IDLE;
        scl_d        = 1'b1;
        count_ctrl_d = 7'd0;
      end
    endcase

    if (bit_end) begin
      case (state_master)
        SM_SEND_ADDRESS: count_d = (count_q == ADDR_LAST) ? 4'd0 : count_q + 4'd1;
        SM_OUTPUT_DATA:  count_d = (count_q == DATA_LAST) ? 4'd0 : count_q + 4'd1;
        SM_STORE_DATA:   count_d = (count_q == DATA_LAST) ? 4'd0 : count_q + 4'd1;
        default:         count_d = count_q;
      endcase
    end

    if (abort) begin
      state_d      = G_IDLE;
      scl_d        = 1'b1;
      count_ctrl_d = 7'd0;
      count_d      = 4'd0;
    end

    if (rst_count) begin
      count_d = 4'd0;
    end

    // Strobes are registered but must coincide with the terminal cycle they
    // mark, so they are set one cycle ahead from the predicted next state.
    high_last_next  = (state_d == G_HIGH) && (count_ctrl_d == HIGH_LAST);
    wait_for_sync_d = (state_d == G_START) && (count_ctrl_d == START_LAST);
    add_sent_d      = high_last_next && (state_master == SM_SEND_ADDRESS) &&
                      (count_q == ADDR_LAST);
    data_sent_d     = high_last_next && (state_master == SM_OUTPUT_DATA) &&
                      (count_q == DATA_LAST);
    data_received_d = high_last_next && (state_master == SM_STORE_DATA) &&
                      (count_q == DATA_LAST);
  end

  // State, SCL, counters and strobes register with asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= G_IDLE;
      scl_q           <= 1'b1;
      count_ctrl_q    <= 7'd0;
      count_q         <= 4'd0;
      wait_for_sync_q <= 1'b0;
      add_sent_q      <= 1'b0;
      data_sent_q     <= 1'b0;
      data_received_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      scl_q           <= scl_d;
      count_ctrl_q    <= count_ctrl_d;
      count_q         <= count_d;
      wait_for_sync_q <= wait_for_sync_d;
      add_sent_q      <= add_sent_d;
      data_sent_q     <= data_sent_d;
      data_received_q <= data_received_d;
    end
  end

  assign scl           = scl_q;
  assign count_ctrl    = count_ctrl_q;
  assign count         = count_q;
  assign wait_for_sync = wait_for_sync_q;
  assign add_sent      = add_sent_q;
  assign data_sent     = data_sent_q;
  assign data_received = data_received_q;

endmodule
`default_nettype wire

// File: tb/tb_scl_generate.sv
`default_nettype none
// ============================================================================
// Module   : tb_scl_generate
// Purpose  : Directed self-checking bench for scl_generate: reset, START,
//            address/write/read bytes, ACK slots, stretching, STOP, abort
//            and asynchronous reset mid-transfer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_scl_generate;

  localparam logic [3:0] S_NONE = 4'b0000;
  localparam logic [3:0] S_WFS  = 4'b1000;
  localparam logic [3:0] S_ADD  = 4'b0100;
  localparam logic [3:0] S_DS   = 4'b0010;
  localparam logic [3:0] S_DR   = 4'b0001;

  logic       clk;
  logic       rst_n;
  logic [3:0] state_master;
  logic       free;
  logic       rst_count;
  logic       scl_in;
  logic       scl;
  logic [6:0] count_ctrl;
  logic [3:0] count;
  logic       wait_for_sync;
  logic       add_sent;
  logic       data_sent;
  logic       data_received;
  logic       stretch;
  logic [3:0] strobes;

  int n_cmp;
  int n_err;

  scl_generate dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .state_master  (state_master),
    .free          (free),
    .rst_count     (rst_count),
    .scl_in        (scl_in),
    .scl           (scl),
    .count_ctrl    (count_ctrl),
    .count         (count),
    .wait_for_sync (wait_for_sync),
    .add_sent      (add_sent),
    .data_sent     (data_sent),
    .data_received (data_received)
  );

  // Bus SCL follows our drive unless a slave is holding it low
  assign scl_in  = stretch ? 1'b0 : scl;
  assign strobes = {wait_for_sync, add_sent, data_sent, data_received};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Idle -> Ready, check the 6-cycle START, then hand over to Send_Address
  task automatic start_seq();
    state_master = 4'd1;
    free         = 1'b0;
    tick();
    for (int i = 0; i < 6; i++) begin
      check("start_scl", 32'(scl), 32'd1);
      check("start_cc", 32'(count_ctrl), 32'(i));
      check("start_strb", 32'(strobes), (i == 5) ? 32'(S_WFS) : 32'(S_NONE));
      if (i < 5) tick();
    end
    state_master = 4'd2;
    tick();
  endtask

  // One full bit starting at its first low cycle
  task automatic run_bit(input logic [3:0] sm, input logic [3:0] cnt,
                         input logic [3:0] strb, input int n_stretch);
    state_master = sm;
    for (int j = 0; j < 6; j++) begin
      check("low_scl", 32'(scl), 32'd0);
      check("low_cc", 32'(count_ctrl), 32'(j));
      check("low_cnt", 32'(count), 32'(cnt));
      check("low_strb", 32'(strobes), 32'(S_NONE));
      tick();
    end
    stretch = (n_stretch > 0);
    for (int j = 0; j < n_stretch; j++) begin
      check("str_scl", 32'(scl), 32'd1);
      check("str_cc", 32'(count_ctrl), 32'd0);
      check("str_strb", 32'(strobes), 32'(S_NONE));
      tick();
    end
    stretch = 1'b0;
    for (int j = 0; j < 4; j++) begin
      check("high_scl", 32'(scl), 32'd1);
      check("high_cc", 32'(count_ctrl), 32'(j));
      check("high_cnt", 32'(count), 32'(cnt));
      check("high_strb", 32'(strobes), (j == 3) ? 32'(strb) : 32'(S_NONE));
      tick();
    end
  endtask

  // Directed scenario sequence
  initial begin
    n_cmp        = 0;
    n_err        = 0;
    rst_n        = 1'b0;
    state_master = 4'd0;
    free         = 1'b1;
    rst_count    = 1'b0;
    stretch      = 1'b0;
    tick();
    tick();
    check("rst_scl", 32'(scl), 32'd1);
    check("rst_cc", 32'(count_ctrl), 32'd0);
    check("rst_cnt", 32'(count), 32'd0);
    check("rst_strb", 32'(strobes), 32'(S_NONE));
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("idle_scl", 32'(scl), 32'd1);
      check("idle_cc", 32'(count_ctrl), 32'd0);
    end

    // Address byte, ACK, write byte, ACK, read byte
    start_seq();
    for (int b = 0; b < 8; b++) run_bit(4'd2, 4'(b), (b == 7) ? S_ADD : S_NONE, 0);
    run_bit(4'd5, 4'd0, S_NONE, 0);
    for (int b = 0; b < 8; b++) run_bit(4'd4, 4'(b), (b == 7) ? S_DS : S_NONE, 0);
    run_bit(4'd5, 4'd0, S_NONE, 0);
    for (int b = 0; b < 8; b++) run_bit(4'd7, 4'(b), (b == 7) ? S_DR : S_NONE, 0);

    // Stretched high phase: 7 held cycles then 4 counted; count advances once
    run_bit(4'd4, 4'd0, S_NONE, 7);

    // STOP: full low phase, one extra low cycle, then SCL high and counting
    state_master = 4'd11;
    for (int j = 0; j < 6; j++) begin
      check("stop_low_scl", 32'(scl), 32'd0);
      check("stop_low_cc", 32'(count_ctrl), 32'(j));
      check("stop_low_cnt", 32'(count), 32'd1);
      tick();
    end
    check("stop_hold_scl", 32'(scl), 32'd0);
    check("stop_hold_cc", 32'(count_ctrl), 32'd0);
    tick();
    for (int j = 1; j < 6; j++) begin
      check("stop_scl", 32'(scl), 32'd1);
      check("stop_cc", 32'(count_ctrl), 32'(j));
      check("stop_strb", 32'(strobes), 32'(S_NONE));
      tick();
    end
    free         = 1'b1;
    state_master = 4'd0;
    tick();
    check("stop_idle_scl", 32'(scl), 32'd1);
    check("stop_idle_cc", 32'(count_ctrl), 32'd0);
    check("stop_idle_cnt", 32'(count), 32'd1);
    rst_count = 1'b1;
    tick();
    rst_count = 1'b0;
    check("rst_count_cnt", 32'(count), 32'd0);

    // Abort in the high phase of address bit 2
    start_seq();
    run_bit(4'd2, 4'd0, S_NONE, 0);
    run_bit(4'd2, 4'd1, S_NONE, 0);
    repeat (7) tick();
    check("abort_pre_scl", 32'(scl), 32'd1);
    check("abort_pre_cc", 32'(count_ctrl), 32'd1);
    check("abort_pre_cnt", 32'(count), 32'd2);
    free = 1'b1;
    tick();
    check("abort_scl", 32'(scl), 32'd1);
    check("abort_cc", 32'(count_ctrl), 32'd0);
    check("abort_cnt", 32'(count), 32'd0);
    check("abort_strb", 32'(strobes), 32'(S_NONE));
    state_master = 4'd0;
    tick();
    check("abort_idle_cc", 32'(count_ctrl), 32'd0);
    check("abort_idle_strb", 32'(strobes), 32'(S_NONE));

    // Asynchronous reset in the high phase of address bit 1
    start_seq();
    run_bit(4'd2, 4'd0, S_NONE, 0);
    repeat (8) tick();
    check("pre_arst_cc", 32'(count_ctrl), 32'd2);
    check("pre_arst_cnt", 32'(count), 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_scl", 32'(scl), 32'd1);
    check("arst_cc", 32'(count_ctrl), 32'd0);
    check("arst_cnt", 32'(count), 32'd0);
    check("arst_strb", 32'(strobes), 32'(S_NONE));
    state_master = 4'd0;
    free         = 1'b1;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_arst_scl", 32'(scl), 32'd1);
      check("post_arst_cc", 32'(count_ctrl), 32'd0);
      check("post_arst_strb", 32'(strobes), 32'(S_NONE));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
